dp_timing_gen: RTL and testbench

Parametrised DisplayPort stream timing generator for the main-link clock domain. A fractional pixel accumulator produces line strobes at the average pixel rate from a non-integer ratio of pixel clock to link clock. Line and frame strobes feed the DP framer, and a DMA prefetch strobe with a programmable lead fires ahead of each frame. Timing configuration is double-buffered and only takes effect at a frame boundary, so mode changes never produce a torn frame.

---
 rtl/dp_timing_gen.sv | 153 +++++++++++++++
 tb/tb_dp_timing_gen.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : dp_timing_gen
//  Purpose  : DisplayPort stream timing generator for the main-link clock
//             domain. A fractional pixel accumulator produces line strobes at
//             the average pixel rate. Line, frame and DMA-prefetch strobes are
//             derived from a line counter. Timing configuration is
//             double-buffered and only applied at a frame boundary, or at
//             once while the generator is stopped.
//
//  Ports    : clk, reset        link clock, synchronous active-high reset
//             enable            run; low freezes counters and quiets strobes
//             htot/vtot/vact    line length, frame length, active lines
//             inc               pixels per clk, FW fraction bits
//             dma_lead          lines ahead of frame start for dmastart
//             cfg_update        request to load the shadow configuration
//             hstart/vstart     one-cycle line / frame strobes
//             dmastart          one-cycle DMA prefetch strobe
//             vactive, line     current line is active / current line index
//             frame_cnt         frames started, wraps
//             cfg_pending       update requested but not yet applied
//
//  Revision : 1.0  initial release
// ============================================================================
module dp_timing_gen #(
    parameter int CW = 16,
    parameter int FW = 15,
    parameter int IW = FW + 2,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [CW-1:0] htot,
    input  logic [CW-1:0] vtot,
    input  logic [CW-1:0] vact,
    input  logic [IW-1:0] inc,
    input  logic [LW-1:0] dma_lead,
    input  logic          cfg_update,
    output logic          hstart,
    output logic          vstart,
    output logic          dmastart,
    output logic          vactive,
    output logic [CW-1:0] line,
    output logic [CW-1:0] frame_cnt,
    output logic          cfg_pending
);

    localparam int AW = CW + FW;
    // Common width for comparing the lead against the frame length.
    localparam int MW = (CW > LW) ? CW : LW;

    // Shadow configuration: the only values the counters ever use.
    logic [CW-1:0] s_htot;
    logic [CW-1:0] s_vtot;
    logic [CW-1:0] s_vact;
    logic [IW-1:0] s_inc;
    logic [LW-1:0] s_lead;

    logic [AW-1:0] acc;

    logic [CW-1:0] vtot_eff;
    logic [CW-1:0] line_inc;
    logic [CW-1:0] dma_line;
    logic [CW-1:0] line_next;
    logic [CW-1:0] vact_next;
    logic [AW-1:0] inc_ext;
    logic [AW-1:0] htot_ext;
    logic [AW-1:0] acc_next;
    logic          wrap;
    logic          run_wrap;
    logic          frame_start;
    logic          lead_at_start;
    logic          dma_hit;
    logic          apply;

    always_comb begin
        // A zero frame length behaves as a one-line frame.
        vtot_eff = (s_vtot == '0) ? CW'(1) : s_vtot;

        inc_ext  = AW'(s_inc);
        htot_ext = {s_htot, {FW{1'b0}}};

        // Line boundary once the whole-pixel part reaches the line length;
        // the fractional remainder carries into the next line.
        wrap     = (acc[AW-1:FW] >= s_htot);
        acc_next = wrap ? (acc - htot_ext + inc_ext) : (acc + inc_ext);

        line_inc    = (line == vtot_eff - CW'(1)) ? '0 : line + CW'(1);
        run_wrap    = enable & wrap;
        frame_start = run_wrap & (line_inc == '0);

        // A lead of zero, or one reaching past the frame start, collapses
        // onto the frame start itself.
        lead_at_start = (s_lead == '0) || (MW'(s_lead) >= MW'(vtot_eff));
        dma_line      = lead_at_start ? '0 : (vtot_eff - CW'(s_lead));
        dma_hit       = run_wrap & (line_inc == dma_line);

        // Pending configuration lands at a frame start, or immediately while
        // stopped since no frame can be torn then.
        apply = cfg_pending & (~enable | frame_start);

        line_next = run_wrap ? line_inc : line;
        vact_next = apply ? vact : s_vact;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= '0;
            line        <= '0;
            frame_cnt   <= '0;
            hstart      <= 1'b0;
            vstart      <= 1'b0;
            dmastart    <= 1'b0;
            cfg_pending <= 1'b0;
            s_htot      <= htot;
            s_vtot      <= vtot;
            s_vact      <= vact;
            s_inc       <= inc;
            s_lead      <= dma_lead;
            vactive     <= (vact != '0);
        end else begin
            if (enable) begin
                acc <= acc_next;
            end
            line <= line_next;
            if (frame_start) begin
                frame_cnt <= frame_cnt + CW'(1);
            end
            hstart   <= run_wrap;
            vstart   <= frame_start;
            dmastart <= dma_hit;

            // A request arriving on the apply cycle stays pending for the
            // following frame boundary.
            cfg_pending <= cfg_update | (cfg_pending & ~apply);

            if (apply) begin
                s_htot <= htot;
                s_vtot <= vtot;
                s_vact <= vact;
                s_inc  <= inc;
                s_lead <= dma_lead;
            end

            // Tracks the line and shadow active count that are in effect
            // from the next cycle on.
            vactive <= (line_next < vact_next);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dp_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dp_timing_gen
//  Purpose  : Self-checking bench for dp_timing_gen: a table of
//             configurations with hand-derived strobe counts, hand-written
//             multi-cycle sequences, and a randomized run, all shadowed by a
//             cycle-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dp_timing_gen;

    localparam int     CW   = 16;
    localparam int     FW   = 15;
    localparam int     IW   = FW + 2;
    localparam int     LW   = 4;
    localparam longint ONE  = 64'd1 << FW;
    localparam longint AMOD = 64'd1 << (CW + FW);
    localparam int     LMOD = 1 << CW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [CW-1:0] htot = '0;
    logic [CW-1:0] vtot = '0;
    logic [CW-1:0] vact = '0;
    logic [IW-1:0] inc = '0;
    logic [LW-1:0] dma_lead = '0;
    logic          cfg_update = 1'b0;
    logic          hstart;
    logic          vstart;
    logic          dmastart;
    logic          vactive;
    logic [CW-1:0] line;
    logic [CW-1:0] frame_cnt;
    logic          cfg_pending;

    dp_timing_gen #(.CW(CW), .FW(FW), .IW(IW), .LW(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .htot       (htot),
        .vtot       (vtot),
        .vact       (vact),
        .inc        (inc),
        .dma_lead   (dma_lead),
        .cfg_update (cfg_update),
        .hstart     (hstart),
        .vstart     (vstart),
        .dmastart   (dmastart),
        .vactive    (vactive),
        .line       (line),
        .frame_cnt  (frame_cnt),
        .cfg_pending(cfg_pending)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    longint m_acc;
    int     m_line, m_frame;
    bit     m_hs, m_vs, m_dma, m_pend, m_vact;
    int     sh_htot, sh_vtot, sh_vact, sh_inc, sh_lead;

    function automatic void load_shadow();
        sh_htot = int'(htot);
        sh_vtot = int'(vtot);
        sh_vact = int'(vact);
        sh_inc  = int'(inc);
        sh_lead = int'(dma_lead);
    endfunction

    // Advances the model by one clock using the inputs about to be sampled.
    task automatic model_step();
        int vt;
        int entered;
        bit app;
        if (reset) begin
            m_acc = 0; m_line = 0; m_frame = 0;
            m_hs = 0; m_vs = 0; m_dma = 0; m_pend = 0;
            load_shadow();
            m_vact = (0 < sh_vact);
        end else begin
            m_hs = 0; m_vs = 0; m_dma = 0;
            vt = (sh_vtot == 0) ? 1 : sh_vtot;
            if (enable) begin
                if ((m_acc / ONE) >= sh_htot) begin
                    m_acc   = (m_acc - longint'(sh_htot) * ONE + sh_inc) % AMOD;
                    entered = (m_line == vt - 1) ? 0 : (m_line + 1) % LMOD;
                    m_line  = entered;
                    m_hs    = 1;
                    if (entered == 0) begin
                        m_vs    = 1;
                        m_frame = (m_frame + 1) % LMOD;
                    end
                    if (sh_lead == 0 || sh_lead >= vt) m_dma = (entered == 0);
                    else                               m_dma = (entered == vt - sh_lead);
                end else begin
                    m_acc = (m_acc + sh_inc) % AMOD;
                end
            end
            app    = m_pend && (m_vs || !enable);
            m_pend = cfg_update || (m_pend && !app);
            if (app) load_shadow();
            m_vact = (m_line < sh_vact);
        end
    endtask

    task automatic expect_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        tests++;
        if ({hstart, vstart, dmastart, vactive, cfg_pending, line, frame_cnt} !==
            {m_hs, m_vs, m_dma, m_vact, m_pend, CW'(m_line), CW'(m_frame)}) begin
            fails++;
            $display("FAIL model @%0t: got h%b v%b d%b va%b p%b line %0d frame %0d, expected h%b v%b d%b va%b p%b line %0d frame %0d",
                     $time, hstart, vstart, dmastart, vactive, cfg_pending, line, frame_cnt,
                     m_hs, m_vs, m_dma, m_vact, m_pend, m_line, m_frame);
        end
    endtask

    // One clock: model from current inputs, then sample outputs after the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic set_in(input int h, input int v, input int va, input int i, input int ld);
        htot     = CW'(h);
        vtot     = CW'(v);
        vact     = CW'(va);
        inc      = IW'(i);
        dma_lead = LW'(ld);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    typedef struct {
        int h, v, va, inc, lead, n, eh, ev, ed;
    } vec_t;

    vec_t tbl[9];
    int   hl[$];
    int   ht[$];
    int   exp_l[6] = '{1, 2, 0, 1, 2, 0};
    int   exp_t[4] = '{9, 13, 19, 25};

    initial begin
        int ch, cv, cd, bad, first, vs_k, l0;
        logic pend_at_vs;
        logic [CW-1:0] f0;

        // {htot, vtot, vact, inc, lead, cycles, hstarts, vstarts, dmastarts}
        tbl[0] = '{4, 3, 2, 32768, 1, 40,  9,  3,  3};
        tbl[1] = '{4, 4, 2, 32768, 0, 40,  9,  2,  2};
        tbl[2] = '{4, 4, 2, 32768, 6, 40,  9,  2,  2};
        tbl[3] = '{4, 4, 2, 32768, 3, 40,  9,  2,  3};
        tbl[4] = '{0, 3, 2, 32768, 1, 40, 40, 13, 13};
        tbl[5] = '{4, 3, 2,     0, 1, 40,  0,  0,  0};
        tbl[6] = '{4, 0, 2, 32768, 1, 40,  9,  9,  9};
        tbl[7] = '{3, 3, 2, 24576, 0, 40,  9,  3,  3};
        tbl[8] = '{4, 3, 2, 49152, 0, 40, 14,  4,  4};

        set_in(4, 3, 2, 32768, 1);
        enable = 1'b1;
        do_reset();
        expect_eq("reset_line", line, 0);
        expect_eq("reset_strobes", {hstart, vstart, dmastart, cfg_pending}, 0);
        expect_eq("reset_vactive", vactive, 1);

        for (int r = 0; r < 9; r++) begin
            set_in(tbl[r].h, tbl[r].v, tbl[r].va, tbl[r].inc, tbl[r].lead);
            enable = 1'b1;
            do_reset();
            ch = 0; cv = 0; cd = 0;
            repeat (tbl[r].n) begin
                cycle();
                if (hstart === 1'b1)   ch++;
                if (vstart === 1'b1)   cv++;
                if (dmastart === 1'b1) cd++;
            end
            expect_eq($sformatf("tbl%0d_hstarts", r), ch, tbl[r].eh);
            expect_eq($sformatf("tbl%0d_vstarts", r), cv, tbl[r].ev);
            expect_eq($sformatf("tbl%0d_dmastarts", r), cd, tbl[r].ed);
        end

        // Integer rate: line sequence and spacing at each hstart.
        set_in(4, 3, 2, 32768, 1);
        do_reset();
        hl.delete(); ht.delete();
        for (int k = 1; k <= 26; k++) begin
            cycle();
            if (hstart === 1'b1) begin
                hl.push_back(int'(line));
                ht.push_back(k);
            end
        end
        expect_eq("int_hcount", hl.size(), 6);
        for (int i = 0; i < 6 && i < hl.size(); i++) begin
            expect_eq($sformatf("int_line%0d", i), hl[i], exp_l[i]);
            expect_eq($sformatf("int_time%0d", i), ht[i], 5 + 4 * i);
        end

        // Double-buffered update: htot 4 -> 6 requested mid-frame.
        set_in(4, 3, 2, 32768, 1);
        do_reset();
        repeat (6) cycle();
        htot = CW'(6);
        cfg_update = 1'b1;
        cycle();
        cfg_update = 1'b0;
        expect_eq("upd_pending_set", cfg_pending, 1);
        f0 = frame_cnt;
        ht.delete();
        vs_k = -1;
        pend_at_vs = 1'bx;
        for (int k = 8; k <= 30; k++) begin
            cycle();
            if (hstart === 1'b1) ht.push_back(k);
            if (vstart === 1'b1) begin
                vs_k = k;
                pend_at_vs = cfg_pending;
            end
        end
        expect_eq("upd_hcount", ht.size(), 4);
        for (int i = 0; i < 4 && i < ht.size(); i++)
            expect_eq($sformatf("upd_time%0d", i), ht[i], exp_t[i]);
        expect_eq("upd_vstart_time", vs_k, 13);
        expect_eq("upd_pending_clear", pend_at_vs, 0);
        expect_eq("upd_frame_step", frame_cnt, CW'(f0 + 1));

        // Enable dropped for 10 cycles mid-line.
        set_in(4, 3, 2, 32768, 1);
        do_reset();
        repeat (6) cycle();
        l0 = int'(line);
        enable = 1'b0;
        bad = 0;
        repeat (10) begin
            cycle();
            if (hstart !== 1'b0 || vstart !== 1'b0 || dmastart !== 1'b0) bad++;
            if (int'(line) != l0) bad++;
        end
        expect_eq("dis_quiet_hold", bad, 0);
        enable = 1'b1;
        first = -1;
        for (int k = 17; k <= 24; k++) begin
            cycle();
            if (hstart === 1'b1 && first < 0) first = k;
        end
        expect_eq("dis_resume_time", first, 19);

        // One-cycle reset mid-frame.
        for (int k = 25; k <= 30; k++) cycle();
        expect_eq("pre_rst_frame", frame_cnt, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        expect_eq("rst_line", line, 0);
        expect_eq("rst_frame", frame_cnt, 0);
        bad = 0;
        repeat (4) begin
            cycle();
            if (hstart !== 1'b0 || vstart !== 1'b0 || dmastart !== 1'b0) bad++;
        end
        expect_eq("rst_quiet", bad, 0);
        cycle();
        expect_eq("rst_first_h", hstart, 1);

        // inc = 0 never produces a line.
        set_in(4, 3, 2, 0, 1);
        do_reset();
        ch = 0;
        repeat (1000) begin
            cycle();
            if (hstart === 1'b1) ch++;
        end
        expect_eq("inc0_no_h", ch, 0);

        // Randomized run against the model.
        set_in(3, 3, 2, 32768, 1);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cfg_update = ($urandom_range(0, 29) == 0);
            if (enable) enable = ($urandom_range(0, 24) != 0);
            else        enable = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 9) == 0)
                set_in($urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 6),
                       ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1 << 13, (1 << 17) - 1),
                       $urandom_range(0, 7));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
